// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcode constants, hazard pair table and FSM state type
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  localparam logic [3:0] OP_BR    = 4'b1001;
  localparam logic [3:0] OP_BRC   = 4'b1010;
  localparam logic [3:0] OP_BRSUB = 4'b1011;
  localparam logic [3:0] OP_RET   = 4'b1100;

  // Each entry is {prev_opcode, cur_opcode}.
  localparam int HAZ_NUM = 8;
  localparam logic [HAZ_NUM-1:0][7:0] HAZ_TABLE = {
    8'h84, 8'h5D, 8'hE5, 8'h1D, 8'hF8, 8'hE8, 8'h2F, 8'h63
  };

  typedef enum logic [1:0] {
    ST_DECODE = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2
  } id_state_e;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_BRC) || (op == OP_BRSUB) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/id_hazard.sv
// rtl/id_hazard.sv - combinational lookup of (prev, cur) opcode pairs in the hazard table
module id_hazard
  import cpu_pkg::*;
(
  input  logic [3:0] prev_op_i,
  input  logic [3:0] cur_op_i,
  output logic       hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < HAZ_NUM; i++) begin
      if (HAZ_TABLE[i] == {prev_op_i, cur_op_i}) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/id_stg.sv
// rtl/id_stg.sv - decode stage: field decode, one-cycle hazard stall, branch resolve and flush
module id_stg #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  input  logic               Z,
  input  logic               N,
  input  logic               ex_ready,
  output logic               stall,
  output logic               redirect,
  output logic [ADDR_W-1:0]  redirect_addr,
  output logic               dec_valid,
  output logic [3:0]         dec_opcode,
  output logic [1:0]         dec_ra,
  output logic [1:0]         dec_rb,
  output logic [7:0]         dec_imm,
  output logic [ADDR_W-1:0]  dec_pc
);
  import cpu_pkg::*;

  id_state_e          state_q, state_d;
  logic [3:0]         prev_q, prev_d;
  logic [ADDR_W-1:0]  link_q, link_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic               redir_q, redir_d;
  logic               dv_q, dv_d;
  logic [INSTR_W-1:0] word_q, word_d;

  logic [ADDR_W-1:0]  w_addr;
  logic [3:0]         w_op;
  logic [7:0]         w_imm;
  logic               haz_hit, hazard, is_br, taken, ex_block, accept;
  logic [ADDR_W-1:0]  target;

  assign w_addr = instruction[INSTR_W-1 -: ADDR_W];
  assign w_op   = instruction[15:12];
  assign w_imm  = instruction[7:0];

  id_hazard u_hazard (
    .prev_op_i (prev_q),
    .cur_op_i  (w_op),
    .hit_o     (haz_hit)
  );

  // Branch opcodes never appear as the second half of a pair, but redirect still wins.
  assign is_br    = is_branch(w_op);
  assign hazard   = haz_hit && !is_br;
  assign ex_block = dv_q && !ex_ready;
  assign target   = (w_op == OP_RET) ? link_q : ADDR_W'(w_imm);

  always_comb begin
    case (w_op)
      OP_BR, OP_BRSUB, OP_RET: taken = 1'b1;
      OP_BRC:                  taken = instruction[10] ? N : Z;
      default:                 taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    link_d  = link_q;
    redir_d = 1'b0;
    raddr_d = raddr_q;
    dv_d    = ex_block;
    word_d  = word_q;
    accept  = 1'b0;

    case (state_q)
      ST_DECODE: begin
        if (instr_valid && !ex_block) begin
          if (hazard) begin
            state_d = ST_STALL;
            prev_d  = '0;
          end else begin
            accept = 1'b1;
          end
        end
      end
      ST_STALL: accept = instr_valid && !ex_block;
      ST_FLUSH: begin
        if (instr_valid) begin
          state_d = ST_DECODE;
          prev_d  = '0;
        end
      end
      default: state_d = ST_DECODE;
    endcase

    if (accept) begin
      state_d = ST_DECODE;
      if (is_br) begin
        if (taken) begin
          redir_d = 1'b1;
          raddr_d = target;
          state_d = ST_FLUSH;
        end
        if (w_op == OP_BRSUB) link_d = w_addr + ADDR_W'(2);
      end else begin
        prev_d = w_op;
        dv_d   = 1'b1;
        word_d = instruction;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_DECODE;
      prev_q  <= '0;
      link_q  <= '0;
      raddr_q <= '0;
      redir_q <= 1'b0;
      dv_q    <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      link_q  <= link_d;
      raddr_q <= raddr_d;
      redir_q <= redir_d;
      dv_q    <= dv_d;
      word_q  <= word_d;
    end
  end

  // The wrong-path word in FLUSH is consumed, so fetch must not hold it.
  assign stall         = reset && instr_valid && (state_q != ST_FLUSH) && !accept;
  assign redirect      = redir_q;
  assign redirect_addr = raddr_q;
  assign dec_valid     = dv_q;
  assign dec_opcode    = word_q[15:12];
  assign dec_ra        = word_q[11:10];
  assign dec_rb        = word_q[9:8];
  assign dec_imm       = word_q[7:0];
  assign dec_pc        = word_q[INSTR_W-1 -: ADDR_W];

endmodule

// File: tb/tb_id_stg.sv
// tb/tb_id_stg.sv - scoreboard bench for id_stg: hazards, branches, backpressure, reset in FLUSH
module tb_id_stg;

  logic        clk;
  logic        reset;
  logic [23:0] instruction;
  logic        instr_valid;
  logic        Z;
  logic        N;
  logic        ex_ready;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        dec_valid;
  logic [3:0]  dec_opcode;
  logic [1:0]  dec_ra;
  logic [1:0]  dec_rb;
  logic [7:0]  dec_imm;
  logic [7:0]  dec_pc;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  exp_rq[$];
  logic [23:0] exp_w;
  logic [7:0]  exp_a;

  id_stg dut (
    .clk           (clk),
    .reset         (reset),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .Z             (Z),
    .N             (N),
    .ex_ready      (ex_ready),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .dec_valid     (dec_valid),
    .dec_opcode    (dec_opcode),
    .dec_ra        (dec_ra),
    .dec_rb        (dec_rb),
    .dec_imm       (dec_imm),
    .dec_pc        (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers: decoded ops on handshake, redirect targets on each pulse.
  always @(negedge clk) begin
    if (reset && dec_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("dv_extra", dec_valid, 0);
      end else begin
        exp_w = exp_q.pop_front();
        check_eq("dec_fields", {dec_pc, dec_opcode, dec_ra, dec_rb, dec_imm}, exp_w);
      end
    end
    if (redirect) begin
      if (exp_rq.size() == 0) begin
        check_eq("redir_extra", redirect, 0);
      end else begin
        exp_a = exp_rq.pop_front();
        check_eq("redir_addr_sb", redirect_addr, exp_a);
      end
    end
  end

  // Acts as fetch: holds the word while stall=1, then checks the cycle after it is taken.
  task automatic send(input string tag, input logic [23:0] w, input bit decoded,
                      input int exp_stalls, input int exp_redir);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    instruction = w;
    instr_valid = 1'b1;
    if (decoded) exp_q.push_back(w);
    if (exp_redir >= 0) exp_rq.push_back(exp_redir[7:0]);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    check_eq({tag, ":taken"}, done, 1);
    check_eq({tag, ":stalls"}, stalls, exp_stalls);
    check_eq({tag, ":dv"}, dec_valid, decoded);
    check_eq({tag, ":redir"}, redirect, exp_redir >= 0);
    if (exp_redir >= 0) check_eq({tag, ":raddr"}, redirect_addr, exp_redir[7:0]);
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 24'h0;
    instr_valid = 1'b0;
    Z           = 1'b0;
    N           = 1'b0;
    ex_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", stall, 0);
    check_eq("rst_redir", redirect, 0);
    check_eq("rst_raddr", redirect_addr, 0);
    check_eq("rst_dv", dec_valid, 0);
    check_eq("rst_fields", {dec_pc, dec_opcode, dec_ra, dec_rb, dec_imm}, 0);
    reset = 1'b1;

    // RET before any BRSUB goes to the reset link value.
    send("ret0", 24'h06_C0_00, 0, 0, 8'h00);
    send("wp0",  24'h07_20_00, 0, 0, -1);

    // Hazard pairs stall once; a non-pair back-to-back does not.
    send("h_a",  24'h00_80_00, 1, 0, -1);
    send("h_b",  24'h02_44_00, 1, 1, -1);
    send("nh",   24'h03_45_11, 1, 0, -1);
    send("h_c",  24'h04_60_01, 1, 0, -1);
    send("h_d",  24'h05_30_02, 1, 1, -1);

    // BRSUB / RET with a wrong-path word discarded after each.
    send("brsub", 24'h10_B0_24, 0, 0, 8'h24);
    send("wp1",   24'h11_00_00, 0, 0, -1);
    send("ret",   24'h24_C0_00, 0, 0, 8'h12);
    send("wp2",   24'h25_00_00, 0, 0, -1);
    send("post",  24'h12_10_05, 1, 0, -1);
    send("h_e",   24'h13_D0_00, 1, 1, -1);

    // Conditional branches on Z and N.
    Z = 1'b1;
    send("bz_t",  24'h20_A0_30, 0, 0, 8'h30);
    send("wp3",   24'h21_00_00, 0, 0, -1);
    Z = 1'b0;
    send("bz_nt", 24'h20_A0_30, 0, 0, -1);
    send("nt_nx", 24'h21_50_00, 1, 0, -1);
    Z = 1'b1;
    send("bn_nt", 24'h22_A4_30, 0, 0, -1);
    Z = 1'b0;
    N = 1'b1;
    send("bn_t",  24'h20_A4_30, 0, 0, 8'h30);
    send("wp4",   24'h21_00_00, 0, 0, -1);
    N = 1'b0;

    // Backpressure holds decoded fields and the next word for 3 cycles.
    send("bp_w1", 24'h30_20_11, 1, 0, -1);
    ex_ready    = 1'b0;
    instruction = 24'h31_41_22;
    instr_valid = 1'b1;
    exp_q.push_back(24'h31_41_22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_stall", stall, 1);
      check_eq("bp_dv", dec_valid, 1);
      check_eq("bp_hold", {dec_pc, dec_opcode, dec_ra, dec_rb, dec_imm}, 24'h30_20_11);
      @(posedge clk);
      #1;
    end
    ex_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release", stall, 0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check_eq("bp_w2_dv", dec_valid, 1);

    // Branch held by backpressure resolves with the flags of its accept cycle.
    send("bp_w3", 24'h32_20_33, 1, 0, -1);
    ex_ready    = 1'b0;
    instruction = 24'h33_A0_50;
    instr_valid = 1'b1;
    exp_rq.push_back(8'h50);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("bpb_stall", stall, 1);
      check_eq("bpb_noredir", redirect, 0);
      @(posedge clk);
      #1;
    end
    ex_ready = 1'b1;
    Z        = 1'b1;
    @(negedge clk);
    check_eq("bpb_accept", stall, 0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    Z           = 1'b0;
    check_eq("bpb_redir", redirect, 1);
    check_eq("bpb_raddr", redirect_addr, 8'h50);
    send("wp5", 24'h34_00_00, 0, 0, -1);

    // Link wraps at 0xFE.
    send("brsub_fe", 24'hFE_B0_40, 0, 0, 8'h40);
    send("wp6",      24'hFF_00_00, 0, 0, -1);
    send("ret_wrap", 24'h40_C0_00, 0, 0, 8'h00);
    send("wp7",      24'h41_00_00, 0, 0, -1);

    // Reset asserted while in FLUSH clears everything, including link.
    send("brsub_l", 24'h44_B0_50, 0, 0, 8'h50);
    send("wp8",     24'h45_00_00, 0, 0, -1);
    send("br_fl",   24'h50_90_60, 0, 0, 8'h60);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rf_stall", stall, 0);
    check_eq("rf_redir", redirect, 0);
    check_eq("rf_raddr", redirect_addr, 0);
    check_eq("rf_dv", dec_valid, 0);
    check_eq("rf_fields", {dec_pc, dec_opcode, dec_ra, dec_rb, dec_imm}, 0);
    reset = 1'b1;
    send("rf_dec", 24'h51_10_07, 1, 0, -1);
    send("rf_ret", 24'h52_C0_00, 0, 0, 8'h00);
    send("wp9",    24'h53_00_00, 0, 0, -1);

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_dec_empty", exp_q.size(), 0);
    check_eq("sb_redir_empty", exp_rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
